// File: rtl/green_house_ctrl.sv
// Greenhouse controller: averaged temperature with hysteresis climate control, pH dosing FSM, door FSM.
// Optional door motion timeout / FAULT state enabled by defining DOOR_TIMEOUT_EN.
module green_house_ctrl #(
  parameter int N_TEMP     = 4,
  parameter int W          = 16,
  parameter int TEMP_LO    = 20,
  parameter int TEMP_HI    = 30,
  parameter int HYST       = 2,
  parameter int LIGHT_MIN  = 300,
  parameter int HUM_MIN    = 40,
  parameter int PH_LO      = 55,
  parameter int PH_HI      = 65,
  parameter int DOSE_CYC   = 10,
  parameter int SETTLE_CYC = 100,
  parameter int DOOR_HOLD  = 50,
  parameter int DOOR_TMO   = 200
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sampleEn,
  input  logic [N_TEMP*W-1:0]   tempSen,
  input  logic [W-1:0]          phSen,
  input  logic [W-1:0]          lightSen,
  input  logic [W-1:0]          humiditySen,
  input  logic                  doorPIRIn,
  input  logic                  doorPIROut,
  input  logic                  doorOpenMax,
  input  logic                  doorCloseMax,
  output logic                  heater,
  output logic                  ventilator,
  output logic                  light,
  output logic                  humidityGenerator,
  output logic                  addAlkali,
  output logic                  addAcidic,
  output logic                  doorOpen,
  output logic                  doorClose,
  output logic                  doorFault,
  output logic [W-1:0]          temp
);

  localparam int LG     = $clog2(N_TEMP);
  localparam int SW     = W + LG;
  localparam int PH_MAX = (DOSE_CYC > SETTLE_CYC) ? DOSE_CYC : SETTLE_CYC;
  localparam int PCW    = $clog2(PH_MAX + 1);
  localparam int HCW    = $clog2(DOOR_HOLD + 1);

  localparam logic [W-1:0] T_LO     = W'(TEMP_LO);
  localparam logic [W-1:0] T_LO_OFF = W'(TEMP_LO + HYST);
  localparam logic [W-1:0] T_HI     = W'(TEMP_HI);
  localparam logic [W-1:0] T_HI_OFF = W'(TEMP_HI - HYST);
  localparam logic [W-1:0] L_MIN    = W'(LIGHT_MIN);
  localparam logic [W-1:0] H_MIN    = W'(HUM_MIN);
  localparam logic [W-1:0] P_LO     = W'(PH_LO);
  localparam logic [W-1:0] P_HI     = W'(PH_HI);

  // ---------------------------------------------------------------- sampling
  logic [W-1:0]  ph_q, light_q, hum_q;
  logic          sample_q;
  logic [SW-1:0] sum;

  always_comb begin
    sum = '0;
    for (int unsigned k = 0; k < N_TEMP; k++)
      sum = sum + SW'(tempSen[k*W +: W]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q <= 1'b0;
      temp     <= '0;
      ph_q     <= '0;
      light_q  <= '0;
      hum_q    <= '0;
    end else begin
      sample_q <= sampleEn;
      if (sampleEn) begin
        temp    <= sum[LG +: W];
        ph_q    <= phSen;
        light_q <= lightSen;
        hum_q   <= humiditySen;
      end
    end
  end

  // ---------------------------------------------------------------- climate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      heater            <= 1'b0;
      ventilator        <= 1'b0;
      light             <= 1'b0;
      humidityGenerator <= 1'b0;
    end else if (sample_q) begin
      if (temp < T_LO)
        heater <= 1'b1;
      else if (temp >= T_LO_OFF)
        heater <= 1'b0;
      if (temp > T_HI)
        ventilator <= 1'b1;
      else if (temp <= T_HI_OFF)
        ventilator <= 1'b0;
      light             <= (light_q < L_MIN);
      humidityGenerator <= (hum_q < H_MIN);
    end
  end

  // ---------------------------------------------------------------- pH FSM
  typedef enum logic [1:0] {IDLE, DOSE, SETTLE} ph_state_t;

  ph_state_t      ph_state, ph_next;
  logic [PCW-1:0] ph_cnt, ph_cnt_next;
  logic           alk_q, alk_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_state <= IDLE;
      ph_cnt   <= '0;
      alk_q    <= 1'b0;
    end else begin
      ph_state <= ph_next;
      ph_cnt   <= ph_cnt_next;
      alk_q    <= alk_next;
    end
  end

  // Decision uses the registered sample, so dosing starts one edge after the sample is captured.
  always_comb begin
    ph_next     = ph_state;
    ph_cnt_next = ph_cnt;
    alk_next    = alk_q;
    case (ph_state)
      IDLE: begin
        if (sample_q && (ph_q < P_LO)) begin
          ph_next     = DOSE;
          ph_cnt_next = PCW'(DOSE_CYC - 1);
          alk_next    = 1'b1;
        end else if (sample_q && (ph_q > P_HI)) begin
          ph_next     = DOSE;
          ph_cnt_next = PCW'(DOSE_CYC - 1);
          alk_next    = 1'b0;
        end
      end
      DOSE: begin
        if (ph_cnt == '0) begin
          ph_next     = SETTLE;
          ph_cnt_next = PCW'(SETTLE_CYC - 1);
        end else begin
          ph_cnt_next = ph_cnt - PCW'(1);
        end
      end
      SETTLE: begin
        if (ph_cnt == '0)
          ph_next = IDLE;
        else
          ph_cnt_next = ph_cnt - PCW'(1);
      end
      default: ph_next = IDLE;
    endcase
  end

  assign addAlkali = (ph_state == DOSE) &&  alk_q;
  assign addAcidic = (ph_state == DOSE) && !alk_q;

  // ---------------------------------------------------------------- door FSM
  typedef enum logic [2:0] {
    CLOSED, OPENING, OPEN, CLOSING
`ifdef DOOR_TIMEOUT_EN
    , FAULT
`endif
  } door_state_t;

  door_state_t    door_state, door_next;
  logic [HCW-1:0] hold_cnt, hold_next;
  logic           pir;

  assign pir = doorPIRIn | doorPIROut;

`ifdef DOOR_TIMEOUT_EN
  localparam int TCW = $clog2(DOOR_TMO + 1);
  logic [TCW-1:0] tmo_cnt;
  logic           tmo_hit;

  assign tmo_hit = (tmo_cnt == TCW'(DOOR_TMO - 1));

  // Counts cycles spent in the current motion state; any state change restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tmo_cnt <= '0;
    else if ((door_next != door_state) || !((door_state == OPENING) || (door_state == CLOSING)))
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_cnt + TCW'(1);
  end
`else
  logic [31:0] unused_tmo;
  assign unused_tmo = 32'(DOOR_TMO);
  assign doorFault  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      door_state <= CLOSED;
      hold_cnt   <= '0;
    end else begin
      door_state <= door_next;
      hold_cnt   <= hold_next;
    end
  end

  always_comb begin
    door_next = door_state;
    hold_next = hold_cnt;
    doorOpen  = 1'b0;
    doorClose = 1'b0;
`ifdef DOOR_TIMEOUT_EN
    doorFault = 1'b0;
`endif
    case (door_state)
      CLOSED: begin
        if (pir)
          door_next = OPENING;
      end
      OPENING: begin
        doorOpen = 1'b1;
        if (doorOpenMax) begin
          door_next = OPEN;
          hold_next = HCW'(DOOR_HOLD - 1);
        end
`ifdef DOOR_TIMEOUT_EN
        else if (tmo_hit)
          door_next = FAULT;
`endif
      end
      OPEN: begin
        if (pir)
          hold_next = HCW'(DOOR_HOLD - 1);
        else if (hold_cnt == '0)
          door_next = CLOSING;
        else
          hold_next = hold_cnt - HCW'(1);
      end
      CLOSING: begin
        doorClose = 1'b1;
        if (pir)
          door_next = OPENING;
        else if (doorCloseMax)
          door_next = CLOSED;
`ifdef DOOR_TIMEOUT_EN
        else if (tmo_hit)
          door_next = FAULT;
`endif
      end
`ifdef DOOR_TIMEOUT_EN
      FAULT: begin
        doorFault = 1'b1;
      end
`endif
      default: door_next = CLOSED;
    endcase
  end

endmodule

// File: tb/tb_green_house_ctrl.sv
// Self-checking bench for green_house_ctrl: climate vector table plus pH and door sequences.
module tb_green_house_ctrl;

  localparam int NT = 4;
  localparam int WD = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             sampleEn = 1'b0;
  logic [NT*WD-1:0] tempSen = '0;
  logic [WD-1:0]    phSen = 16'd60;
  logic [WD-1:0]    lightSen = '0;
  logic [WD-1:0]    humiditySen = '0;
  logic             doorPIRIn = 1'b0;
  logic             doorPIROut = 1'b0;
  logic             doorOpenMax = 1'b0;
  logic             doorCloseMax = 1'b0;
  logic             heater, ventilator, light, humidityGenerator;
  logic             addAlkali, addAcidic, doorOpen, doorClose, doorFault;
  logic [WD-1:0]    temp;

  green_house_ctrl #(.N_TEMP(NT), .W(WD)) dut (
    .clk(clk), .rst_n(rst_n), .sampleEn(sampleEn), .tempSen(tempSen),
    .phSen(phSen), .lightSen(lightSen), .humiditySen(humiditySen),
    .doorPIRIn(doorPIRIn), .doorPIROut(doorPIROut),
    .doorOpenMax(doorOpenMax), .doorCloseMax(doorCloseMax),
    .heater(heater), .ventilator(ventilator), .light(light),
    .humidityGenerator(humidityGenerator), .addAlkali(addAlkali),
    .addAcidic(addAcidic), .doorOpen(doorOpen), .doorClose(doorClose),
    .doorFault(doorFault), .temp(temp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [NT*WD-1:0] t;
    logic [WD-1:0]    l, h, et;
    logic             eh, ev, el, ehm;
  } vec_t;

  vec_t tbl[12];
  vec_t exp_q[$];

  function automatic vec_t mk(input logic [WD-1:0] a, b, c, d, l, h, et,
                              input logic eh, ev, el, ehm);
    vec_t v;
    v.t = {d, c, b, a};
    v.l = l; v.h = h; v.et = et;
    v.eh = eh; v.ev = ev; v.el = el; v.ehm = ehm;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int len;
    logic bad;
    vec_t e;

    tbl[0]  = mk(10, 12, 14, 16, 500, 50, 13, 1, 0, 0, 0);
    tbl[1]  = mk(19, 19, 19, 19, 299, 39, 19, 1, 0, 1, 1);
    tbl[2]  = mk(21, 21, 21, 21, 300, 40, 21, 1, 0, 0, 0);
    tbl[3]  = mk(22, 22, 22, 22, 1000, 100, 22, 0, 0, 0, 0);
    tbl[4]  = mk(31, 31, 31, 31, 500, 50, 31, 0, 1, 0, 0);
    tbl[5]  = mk(29, 29, 29, 29, 500, 50, 29, 0, 1, 0, 0);
    tbl[6]  = mk(28, 28, 28, 28, 500, 50, 28, 0, 0, 0, 0);
    tbl[7]  = mk(30, 30, 30, 30, 500, 50, 30, 0, 0, 0, 0);
    tbl[8]  = mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 0, 16'hFFFF, 0, 1, 1, 1);
    tbl[9]  = mk(29, 29, 29, 29, 500, 50, 29, 0, 1, 0, 0);
    tbl[10] = mk(1, 2, 2, 2, 500, 50, 1, 1, 0, 0, 0);
    tbl[11] = mk(20, 20, 20, 20, 500, 50, 20, 1, 0, 0, 0);

    // reset state with clocks running under reset
    repeat (3) @(posedge clk);
    #1;
    chk("reset_temp", 32'(temp), 0);
    chk("reset_outs", {heater, ventilator, light, humidityGenerator, addAlkali,
                       addAcidic, doorOpen, doorClose, doorFault}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // climate table
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      tempSen = tbl[i].t; lightSen = tbl[i].l; humiditySen = tbl[i].h;
      phSen = 16'd60; sampleEn = 1'b1;
      exp_q.push_back(tbl[i]);
      tick();
      chk($sformatf("temp[%0d]", i), 32'(temp), 32'(exp_q[0].et));
      @(negedge clk);
      sampleEn = 1'b0;
      tick();
      e = exp_q.pop_front();
      chk($sformatf("heater[%0d]", i), 32'(heater), 32'(e.eh));
      chk($sformatf("vent[%0d]", i), 32'(ventilator), 32'(e.ev));
      chk($sformatf("light[%0d]", i), 32'(light), 32'(e.el));
      chk($sformatf("hum[%0d]", i), 32'(humidityGenerator), 32'(e.ehm));
      chk($sformatf("heat_vent_excl[%0d]", i), 32'(heater & ventilator), 0);
    end
    repeat (5) tick();
    chk("climate_hold", {heater, ventilator}, 2'b10);

    // pH: alkali dose, ignored samples while settling, then acidic dose
    do_reset();
    @(negedge clk);
    phSen = 16'd40; sampleEn = 1'b1;
    tick();
    chk("alk_not_yet", 32'(addAlkali), 0);
    @(negedge clk);
    sampleEn = 1'b0;
    tick();
    chk("alk_rise", 32'(addAlkali), 1);
    len = 1; bad = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (addAcidic) bad = 1'b1;
      tick();
      if (!addAlkali) break;
      len++;
    end
    chk("alk_len", 32'(len), 10);
    chk("alk_no_acid", 32'(bad), 0);
    @(negedge clk);
    phSen = 16'd90; sampleEn = 1'b1;
    n = 0; bad = 1'b0;
    for (int k = 0; k < 300; k++) begin
      tick();
      n++;
      if (addAlkali) bad = 1'b1;
      if (addAcidic) break;
    end
    chk("acid_delay", 32'(n), 101);
    chk("acid_no_alk", 32'(bad | addAlkali), 0);
    @(negedge clk);
    sampleEn = 1'b0; phSen = 16'd60;
    repeat (3) tick();
    chk("acid_mid", 32'(addAcidic), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("acid_async_rst", 32'(addAcidic), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (30) begin
      tick();
      if (addAcidic | addAlkali) bad = 1'b1;
    end
    chk("acid_aborted", 32'(bad), 0);

    // door: open, ignored limit, hold, close, reopen from CLOSING
    do_reset();
    @(negedge clk);
    doorPIRIn = 1'b1;
    tick();
    chk("door_opening", {doorOpen, doorClose}, 2'b10);
    @(negedge clk);
    doorPIRIn = 1'b0; doorCloseMax = 1'b1;
    tick();
    chk("door_ign_close", {doorOpen, doorClose}, 2'b10);
    @(negedge clk);
    doorCloseMax = 1'b0; doorOpenMax = 1'b1;
    tick();
    chk("door_open", {doorOpen, doorClose}, 2'b00);
    @(negedge clk);
    doorOpenMax = 1'b0;
    n = 0;
    for (int k = 0; k < 200; k++) begin
      tick(); n++;
      if (doorClose) break;
    end
    chk("door_hold", 32'(n), 50);
    @(negedge clk);
    doorPIROut = 1'b1;
    tick();
    chk("door_reopen", {doorOpen, doorClose}, 2'b10);
    @(negedge clk);
    doorPIROut = 1'b0; doorOpenMax = 1'b1;
    tick();
    @(negedge clk);
    doorOpenMax = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    doorPIRIn = 1'b1;
    tick();
    chk("door_reload_open", 32'(doorClose), 0);
    @(negedge clk);
    doorPIRIn = 1'b0;
    n = 0;
    for (int k = 0; k < 200; k++) begin
      tick(); n++;
      if (doorClose) break;
    end
    chk("door_reload_hold", 32'(n), 50);
    @(negedge clk);
    doorPIRIn = 1'b1; doorCloseMax = 1'b1;
    tick();
    chk("door_pir_prio", {doorOpen, doorClose}, 2'b10);
    @(negedge clk);
    doorPIRIn = 1'b0; doorCloseMax = 1'b0; doorOpenMax = 1'b1;
    tick();
    @(negedge clk);
    doorOpenMax = 1'b0;
    n = 0;
    for (int k = 0; k < 200; k++) begin
      tick(); n++;
      if (doorClose) break;
    end
    chk("door_hold2", 32'(n), 50);
    @(negedge clk);
    doorCloseMax = 1'b1;
    tick();
    chk("door_closed", {doorOpen, doorClose}, 2'b00);
    @(negedge clk);
    doorCloseMax = 1'b0; doorOpenMax = 1'b1;
    tick();
    @(negedge clk);
    doorOpenMax = 1'b0;
    tick();
    chk("door_ign_open", {doorOpen, doorClose}, 2'b00);

    // motion timeout
    @(negedge clk);
    doorPIRIn = 1'b1;
    tick();
    @(negedge clk);
    doorPIRIn = 1'b0;
`ifdef DOOR_TIMEOUT_EN
    n = 0;
    for (int k = 0; k < 400; k++) begin
      tick(); n++;
      if (doorFault) break;
    end
    chk("tmo_cycles", 32'(n), 200);
    chk("tmo_outs", {doorOpen, doorClose, doorFault}, 3'b001);
    @(negedge clk);
    doorPIRIn = 1'b1;
    tick();
    @(negedge clk);
    doorPIRIn = 1'b0;
    tick();
    chk("fault_sticky", {doorOpen, doorClose, doorFault}, 3'b001);
    #2;
    rst_n = 1'b0;
    #1;
    chk("fault_rst", 32'(doorFault), 0);
`else
    repeat (250) tick();
    chk("no_tmo", {doorOpen, doorClose, doorFault}, 3'b100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("motion_async_rst", 32'(doorOpen), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (10) begin
      tick();
      if (doorOpen | doorClose | doorFault) bad = 1'b1;
    end
    chk("motion_aborted", 32'(bad), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/green_house_ctrl.md
GREEN_HOUSE_CTRL -- requirements
Module: green_house_ctrl

Interface
REQ-001 SHALL have parameter N_TEMP, default 4, temperature channel count; legal values 1, 2, 4, 8.
REQ-002 SHALL have parameter W, default 16, sensor word width in bits.
REQ-003 SHALL have parameters TEMP_LO=20, TEMP_HI=30, HYST=2, LIGHT_MIN=300, HUM_MIN=40, PH_LO=55, PH_HI=65, DOSE_CYC=10, SETTLE_CYC=100, DOOR_HOLD=50, DOOR_TMO=200; TEMP_LO+HYST SHALL be less than TEMP_HI-HYST.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have inputs sampleEn (1), tempSen (N_TEMP*W, channel k in bits [k*W+W-1:k*W]), phSen, lightSen and humiditySen (W each).
REQ-007 SHALL have inputs doorPIRIn, doorPIROut, doorOpenMax and doorCloseMax (1 each).
REQ-008 SHALL have outputs heater, ventilator, light, humidityGenerator, addAlkali, addAcidic, doorOpen, doorClose and doorFault (1 each), and temp (W).

Function
REQ-009 On an edge with sampleEn=1, SHALL register all sensor inputs and set temp to floor(sum of channels / N_TEMP), computed with log2(N_TEMP) extra guard bits, so temp is valid 1 cycle after the sampleEn edge.
REQ-010 Climate outputs SHALL update on the edge after temp updates (latency 2) and hold between samples.
REQ-011 heater SHALL set when temp<TEMP_LO and clear when temp>=TEMP_LO+HYST; ventilator SHALL set when temp>TEMP_HI and clear when temp<=TEMP_HI-HYST; the two SHALL never both be 1.
REQ-012 light SHALL equal (registered lightSen < LIGHT_MIN); humidityGenerator SHALL equal (registered humiditySen < HUM_MIN).
REQ-013 The pH FSM SHALL have states IDLE, DOSE and SETTLE; in IDLE, on a sample with phSen<PH_LO it SHALL enter DOSE with addAlkali=1, and with phSen>PH_HI it SHALL enter DOSE with addAcidic=1.
REQ-014 DOSE SHALL last exactly DOSE_CYC cycles; SETTLE SHALL then last SETTLE_CYC cycles with pH samples ignored, then return to IDLE; addAlkali and addAcidic SHALL never both be 1.
REQ-015 The door FSM SHALL have states CLOSED, OPENING, OPEN and CLOSING; in CLOSED, doorPIRIn or doorPIROut SHALL enter OPENING.
REQ-016 OPENING SHALL drive doorOpen=1 until doorOpenMax=1, then enter OPEN.
REQ-017 OPEN SHALL load the hold counter with DOOR_HOLD and reload it on any PIR input; on expiry it SHALL enter CLOSING.
REQ-018 CLOSING SHALL drive doorClose=1 until doorCloseMax=1, then enter CLOSED; a PIR input during CLOSING SHALL enter OPENING on the next edge, and PIR takes priority over a simultaneous doorCloseMax.
REQ-019 doorOpen and doorClose SHALL never both be 1; in OPEN and CLOSED both SHALL be 0.
REQ-020 A limit switch asserted in a state that does not wait for it SHALL be ignored.

Reset
REQ-021 On rst_n=0, immediately and regardless of clk, all outputs SHALL be 0 and temp SHALL be 0.
REQ-022 On rst_n=0, the pH FSM SHALL go to IDLE, the door FSM to CLOSED, and all counters and sensor registers SHALL clear.
REQ-023 Reset asserted mid-dose or mid-motion SHALL abort the operation with no pulse completion after release.

Configuration
REQ-024 Macro DOOR_TIMEOUT_EN defined: OPENING or CLOSING lasting DOOR_TMO cycles without the awaited limit switch SHALL enter FAULT, with doorOpen=doorClose=0 and doorFault=1; FAULT SHALL exit only by reset.
REQ-025 Macro DOOR_TIMEOUT_EN undefined: there SHALL be no FAULT state, doorFault SHALL be tied to 0, and motion SHALL wait indefinitely.

Verification
REQ-026 Channels 10,12,14,16 (N_TEMP=4) with one sampleEn -> temp=13 one cycle later; heater=1 two cycles later; ventilator=0.
REQ-027 Hysteresis sequence temp 19, 21, 22, 31, 29, 28 -> heater 1, 1, 0, 0, 0, 0 and ventilator 0, 0, 0, 1, 1, 0.
REQ-028 phSen=40 sampled -> addAlkali high exactly 10 cycles, then phSen=90 samples ignored for 100 cycles, then addAcidic=1.
REQ-029 doorPIRIn pulse -> doorOpen=1; doorOpenMax -> OPEN; 50 idle cycles -> doorClose=1; doorPIROut during CLOSING -> doorOpen=1 next cycle.
REQ-030 With DOOR_TIMEOUT_EN defined, a PIR pulse and no doorOpenMax for 200 cycles -> doorFault=1 and doorOpen=0; rst_n low -> doorFault=0.
